fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Fetch stage front end. Generates the instruction-memory address stream and buffers
//  fetched words in a small prefetch FIFO. Presents {InstructionD, PCPlus4D, ValidD} to the
//  decode stage as registered outputs, replacing the ProgramCounter/PCAdder/fetch pipe reg.
//  Supports decode stall (hold) and redirect (branch/jump flush to a new PC).
// PARAMETERS
//  DEPTH     4           prefetch FIFO entries; power of two, >=2
//  PC_RESET  32'h0       fetch PC loaded on reset
// PORTS
//  Clk           in   1   clock; all state updates on posedge
//  Reset         in   1   synchronous, active-low reset (0 = reset)
//  IMemAddr      out  32  fetch address = FetchPC
//  IMemReq       out  1   fetch request
//  IMemReady     in   1   memory accepts request; IMemData valid in the same cycle
//  IMemData      in   32  instruction word for IMemAddr
//  StallD        in   1   decode holds; D outputs must not change
//  Redirect      in   1   flush and restart fetch at RedirectPC
//  RedirectPC    in   32  new fetch address; bits[1:0] forced to 0
//  InstructionD  out  32  instruction to decode; 0 (NOP) when ValidD=0
//  PCPlus4D      out  32  address of InstructionD + 4
//  ValidD        out  1   InstructionD holds a real instruction
// BEHAVIOUR
//  Reset (Reset=0 at edge): FetchPC=PC_RESET, count=0, rd/wr ptr=0, InstructionD=0,
//   PCPlus4D=0, ValidD=0. IMemReq=0 while Reset=0. Any transfer in flight is discarded.
//  IMemReq = Reset & ~Redirect & (count<DEPTH) (combinational). IMemAddr = FetchPC.
//  Transfer = IMemReq & IMemReady: push {IMemData, FetchPC+4}; FetchPC += 4.
//  Full check uses the pre-edge count: a pop in the same cycle does not free space.
//  No bypass: a word pushed at edge N reaches the D outputs at edge N+1 at the earliest.
//   Minimum latency from request to ValidD=1 is 2 cycles.
//  D update at each edge, priority high to low:
//   1. Redirect=1: FIFO cleared (count=0, ptrs=0); FetchPC=RedirectPC&~3;
//      InstructionD=0, ValidD=0. Overrides StallD.
//   2. StallD=1: D outputs hold. FIFO still fills until full.
//   3. count>0: pop the head into InstructionD/PCPlus4D; ValidD=1.
//   4. count==0: InstructionD=0, ValidD=0; PCPlus4D holds.
//  Simultaneous push and pop: count unchanged, both pointers advance.
//  Pointers wrap mod DEPTH. FetchPC and PCPlus4 wrap mod 2^32 (32'hFFFFFFFC+4=0).
//  IMemReady=0: FetchPC holds; the same address is re-requested, with no duplicate push.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds output port FetchBubbleCnt [31:0].
//   Reset value 0. Increments (wrapping) at each edge where Reset=1, Redirect=0,
//   StallD=0 and count==0 (decode starved).
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset held 2 cycles, IMemReady=1, IMemData=addr^32'hA5A50000, StallD=0 ->
//     IMemAddr 0,4,8,...; first ValidD=1 two cycles after release, InstructionD=32'hA5A50000,
//     PCPlus4D=4; then one instruction per cycle, no gaps.
//  2. StallD=1 for 8 cycles mid-stream -> D outputs constant; IMemReq drops once 4 entries
//     are buffered; StallD=0 -> next 4 ValidD cycles give consecutive PCPlus4D with no loss
//     or repeat.
//  3. 3 entries buffered and StallD=1, pulse Redirect with RedirectPC=32'h43 ->
//     next cycle ValidD=0, count=0, IMemAddr=32'h40; first valid PCPlus4D=32'h44.
//  4. IMemReady toggled 1,0,0,1,0,1 -> each address pushed exactly once and in order;
//     ValidD gaps equal the starved cycles.
//  5. PC_RESET=32'hFFFFFFF8 -> IMemAddr FFFFFFF8, FFFFFFFC, 00000000; PCPlus4D FFFFFFFC,
//     00000000, 00000004.
//  6. Reset=0 asserted for one cycle with the FIFO full and ValidD=1 -> next cycle all
//     outputs at reset values and fetch restarts at PC_RESET. With FETCH_PERF_CNT_EN,
//     IMemReady=0 for 5 cycles after reset gives FetchBubbleCnt=5 (with StallD=0).

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: fetch PC generation plus prefetch FIFO feeding registered decode outputs
// Define FETCH_PERF_CNT_EN to add FetchBubbleCnt, counting edges where decode is starved
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] IMemAddr,
  output logic        IMemReq,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  input  logic        StallD,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] InstructionD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchBubbleCnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc4_mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic valid_q, valid_d, push, pop, load_d;
  assign IMemReq      = Reset & ~Redirect & (count_q < CW'(DEPTH));
  assign IMemAddr     = fetch_pc_q;
  assign push         = IMemReq & IMemReady;
  assign pop          = ~Redirect & ~StallD & (count_q != '0);
  assign load_d       = Redirect | ~StallD;
  assign InstructionD = instr_q;
  assign PCPlus4D     = pc4_q;
  assign ValidD       = valid_q;
  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    fetch_pc_d = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    instr_d    = load_d ? (pop ? instr_mem_q[rd_ptr_q] : '0) : instr_q;
    pc4_d      = pop ? pc4_mem_q[rd_ptr_q] : pc4_q;
    valid_d    = load_d ? pop : valid_q;
    if (Redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {RedirectPC[31:2], 2'b00};
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= PC_RESET;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= IMemData;
      pc4_mem_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_q;
  assign FetchBubbleCnt = bubble_q;
  always_ff @(posedge Clk) begin
    if (!Reset) bubble_q <= '0;
    else if (~Redirect & ~StallD & (count_q == '0)) bubble_q <= bubble_q + 32'd1;
  end
`endif
endmodule
